// File: rtl/edge_event_reporter.sv
// Per-row persistence filter that turns confirmed level changes into timestamped
// events, funnelled by row priority through single-entry pending slots into a FIFO.
module edge_event_reporter #(
  parameter int ROWS       = 5,
  parameter int PERSIST    = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_WIDTH   = 16,
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int PTR_W = $clog2(FIFO_DEPTH),
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clock,
  input  logic                resetN,
  input  logic                resultIn [0:ROWS-1],
  input  logic                inValid,
  output logic                eventValid,
  input  logic                eventReady,
  output logic [ROW_W-1:0]    eventRow,
  output logic                eventRise,
  output logic [TS_WIDTH-1:0] eventTime,
  output logic [LVL_W-1:0]    fifoLevel,
  output logic [7:0]          dropCount
);

  logic [TS_WIDTH-1:0] ts_reg;
  logic [ROWS-1:0]     pend_valid;
  logic [ROWS-1:0]     pend_rise;
  logic [TS_WIDTH-1:0] pend_time [ROWS];
  logic [ROWS-1:0]     drop;
  logic [ROW_W-1:0]    sel_row;
  logic                any_pend;
  logic                push;
  logic                pop;
  logic [15:0]         drop_sum;
  logic [7:0]          drop_reg;

  logic [ROW_W-1:0]    row_mem  [FIFO_DEPTH];
  logic                rise_mem [FIFO_DEPTH];
  logic [TS_WIDTH-1:0] time_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [LVL_W-1:0]    level_cnt_reg;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) ts_reg <= '0;
    else         ts_reg <= ts_reg + 1'b1;
  end

  // Descending scan so the lowest occupied row wins.
  always_comb begin
    any_pend = 1'b0;
    sel_row  = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (pend_valid[r]) begin
        any_pend = 1'b1;
        sel_row  = ROW_W'(r);
      end
    end
  end

  assign push = any_pend && (level_cnt_reg != LVL_W'(FIFO_DEPTH));
  assign pop  = eventValid && eventReady;

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      logic                level_reg;
      logic [3:0]          run_reg;
      logic                pv_reg;
      logic                pr_reg;
      logic [TS_WIDTH-1:0] pt_reg;
      logic                differ;
      logic                confirm;
      logic                drain;

      assign differ  = inValid && (resultIn[gi] != level_reg);
      assign confirm = differ && (run_reg == 4'(PERSIST - 1));
      assign drain   = push && (sel_row == ROW_W'(gi));
      // A slot being drained on this edge is free for a new confirmation.
      assign drop[gi] = confirm && pv_reg && !drain;

      always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
          level_reg <= 1'b0;
          run_reg   <= '0;
          pv_reg    <= 1'b0;
          pr_reg    <= 1'b0;
          pt_reg    <= '0;
        end else begin
          if (inValid) begin
            if (confirm) begin
              level_reg <= ~level_reg;
              run_reg   <= '0;
            end else if (differ) begin
              run_reg <= run_reg + 1'b1;
            end else begin
              run_reg <= '0;
            end
          end
          if (confirm && !drop[gi]) begin
            pv_reg <= 1'b1;
            pr_reg <= ~level_reg;
            pt_reg <= ts_reg;
          end else if (drain) begin
            pv_reg <= 1'b0;
          end
        end
      end

      assign pend_valid[gi] = pv_reg;
      assign pend_rise[gi]  = pr_reg;
      assign pend_time[gi]  = pt_reg;
    end
  endgenerate

  always_comb begin
    drop_sum = 16'(drop_reg);
    for (int r = 0; r < ROWS; r++) begin
      drop_sum = drop_sum + 16'(drop[r]);
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)               drop_reg <= '0;
    else if (drop_sum > 16'd255) drop_reg <= 8'd255;
    else                       drop_reg <= drop_sum[7:0];
  end

  always_ff @(posedge clock) begin
    if (push) begin
      row_mem[wr_ptr_reg]  <= sel_row;
      rise_mem[wr_ptr_reg] <= pend_rise[sel_row];
      time_mem[wr_ptr_reg] <= pend_time[sel_row];
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_cnt_reg <= '0;
    end else begin
      wr_ptr_reg    <= wr_ptr_reg + PTR_W'(push);
      rd_ptr_reg    <= rd_ptr_reg + PTR_W'(pop);
      level_cnt_reg <= level_cnt_reg + LVL_W'(push) - LVL_W'(pop);
    end
  end

  assign eventValid = (level_cnt_reg != '0);
  assign eventRow   = row_mem[rd_ptr_reg];
  assign eventRise  = rise_mem[rd_ptr_reg];
  assign eventTime  = time_mem[rd_ptr_reg];
  assign fifoLevel  = level_cnt_reg;
  assign dropCount  = drop_reg;

endmodule

// File: tb/tb_edge_event_reporter.sv
// Bench for edge_event_reporter: queue-based event model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_edge_event_reporter;
  localparam int ROWS = 5;
  localparam int PERSIST = 3;
  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        resultIn [0:ROWS-1];
  logic        inValid = 1'b0;
  logic        eventReady = 1'b0;
  logic        eventValid;
  logic [2:0]  eventRow;
  logic        eventRise;
  logic [15:0] eventTime;
  logic [3:0]  fifoLevel;
  logic [7:0]  dropCount;

  edge_event_reporter #(.ROWS(ROWS), .PERSIST(PERSIST), .FIFO_DEPTH(DEPTH), .TS_WIDTH(16)) dut (
    .clock(clock), .resetN(resetN), .resultIn(resultIn), .inValid(inValid),
    .eventValid(eventValid), .eventReady(eventReady), .eventRow(eventRow),
    .eventRise(eventRise), .eventTime(eventTime), .fifoLevel(fifoLevel),
    .dropCount(dropCount)
  );

  always #5 clock = ~clock;

  typedef struct {int row; int rise; int t;} ev_t;

  int errors = 0;
  int checks = 0;

  // Model state
  int   m_level [ROWS];
  int   m_run   [ROWS];
  int   m_pv    [ROWS];
  int   m_prise [ROWS];
  int   m_ptime [ROWS];
  ev_t  m_q [$];
  int   m_drop;
  int   m_ts;
  ev_t  got [$];

  // Output snapshot taken after each edge, used to log the event popped next edge
  logic s_valid = 1'b0;
  ev_t  s_ev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++) begin
      m_level[r] = 0; m_run[r] = 0; m_pv[r] = 0; m_prise[r] = 0; m_ptime[r] = 0;
    end
    m_q.delete();
    m_drop = 0;
    m_ts = 0;
  endtask

  task automatic model_step();
    int drain_r;
    drain_r = -1;
    if (m_q.size() < DEPTH) begin
      for (int r = ROWS - 1; r >= 0; r--) if (m_pv[r] != 0) drain_r = r;
    end
    if (m_q.size() != 0 && eventReady) void'(m_q.pop_front());
    if (drain_r >= 0) begin
      m_q.push_back('{drain_r, m_prise[drain_r], m_ptime[drain_r]});
      m_pv[drain_r] = 0;
    end
    if (inValid) begin
      for (int r = 0; r < ROWS; r++) begin
        if (int'(resultIn[r]) != m_level[r]) begin
          m_run[r]++;
          if (m_run[r] == PERSIST) begin
            m_level[r] = 1 - m_level[r];
            m_run[r] = 0;
            if (m_pv[r] != 0) begin
              if (m_drop < 255) m_drop++;
            end else begin
              m_pv[r] = 1; m_prise[r] = m_level[r]; m_ptime[r] = m_ts;
            end
          end
        end else begin
          m_run[r] = 0;
        end
      end
    end
    m_ts = (m_ts + 1) % 65536;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clock);
      if (!resetN) begin
        model_clear();
      end else begin
        if (s_valid && eventReady) got.push_back(s_ev);
        model_step();
      end
      #1;
      check("cyc_valid", eventValid, m_q.size() != 0);
      check("cyc_level", fifoLevel, m_q.size());
      check("cyc_drop", dropCount, m_drop);
      if (m_q.size() != 0) begin
        check("cyc_row", eventRow, m_q[0].row);
        check("cyc_rise", eventRise, m_q[0].rise);
        check("cyc_time", eventTime, m_q[0].t);
      end
      s_valid = eventValid;
      s_ev = '{int'(eventRow), int'(eventRise), int'(eventTime)};
    end
  end

  task automatic set_rows(input logic [ROWS-1:0] v);
    for (int r = 0; r < ROWS; r++) resultIn[r] = v[r];
  endtask

  // Advance to the negedge before the posedge that samples timestamp n.
  task automatic wait_ts(input int n);
    for (int i = 0; i < 300 && m_ts != n; i++) @(negedge clock);
  endtask

  task automatic check_got(input int idx, input int row, input int rise, input int t);
    if (idx < got.size()) begin
      check("got_row", got[idx].row, row);
      check("got_rise", got[idx].rise, rise);
      check("got_time", got[idx].t, t);
    end else begin
      check("got_missing", got.size(), idx + 1);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clock);
    resetN = 1'b0;
    set_rows('0);
    eventReady = 1'b0;
    @(negedge clock);
    resetN = 1'b1;
    got.delete();
  endtask

  int exp_row  [9] = '{0, 1, 2, 3, 4, 0, 1, 2, 3};
  int exp_rise [9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
  int exp_time [9] = '{2, 2, 2, 2, 2, 10, 10, 10, 10};
  int base;

  initial begin
    set_rows('0);
    // Reset with random inputs
    repeat (6) begin
      @(negedge clock);
      set_rows(5'($urandom));
      inValid = 1'($urandom_range(0, 1));
      eventReady = 1'($urandom_range(0, 1));
      #1;
      check("rst_valid", eventValid, 0);
      check("rst_level", fifoLevel, 0);
      check("rst_drop", dropCount, 0);
    end
    @(negedge clock);
    set_rows('0); inValid = 1'b1; eventReady = 1'b0; resetN = 1'b1;
    repeat (2) @(negedge clock);
    check("post_rst_valid", eventValid, 0);
    check("post_rst_level", fifoLevel, 0);
    check("post_rst_drop", dropCount, 0);

    // Row 2 rise confirmed at timestamp 12, then fall
    wait_ts(10); set_rows(5'b00100);
    wait_ts(13); check("r2_not_yet", eventValid, 0);
    wait_ts(14);
    check("r2_valid", eventValid, 1);
    check("r2_row", eventRow, 2);
    check("r2_rise", eventRise, 1);
    check("r2_time", eventTime, 12);
    eventReady = 1'b1;
    wait_ts(15); set_rows('0);
    check("r2_popped", eventValid, 0);
    wait_ts(20);
    check("r2_count", got.size(), 2);
    check_got(0, 2, 1, 12);
    check_got(1, 2, 0, 17);

    // Row 3 short pulse is filtered out
    wait_ts(22); set_rows(5'b01000);
    wait_ts(24); set_rows('0);
    wait_ts(30);
    check("r3_level", fifoLevel, 0);
    check("r3_valid", eventValid, 0);
    check("r3_count", got.size(), 2);

    // Rows 0 and 4 confirm together at timestamp 20
    reset_pulse();
    wait_ts(18); set_rows(5'b10001);
    wait_ts(21); check("pair_lvl0", fifoLevel, 0);
    wait_ts(22);
    check("pair_lvl1", fifoLevel, 1);
    check("pair_head_row", eventRow, 0);
    check("pair_head_time", eventTime, 20);
    wait_ts(23); check("pair_lvl2", fifoLevel, 2);
    eventReady = 1'b1;
    wait_ts(26);
    check("pair_count", got.size(), 2);
    check_got(0, 0, 1, 20);
    check_got(1, 4, 1, 20);

    // Fill FIFO, hold one pending, drop a re-confirmation, then drain
    reset_pulse();
    set_rows(5'b11111);
    wait_ts(8); set_rows(5'b10000);
    wait_ts(16);
    check("full_level", fifoLevel, 8);
    check("full_drop0", dropCount, 0);
    check("full_head_row", eventRow, 0);
    set_rows(5'b11000);
    wait_ts(20);
    check("full_drop1", dropCount, 1);
    check("full_level_hold", fifoLevel, 8);
    eventReady = 1'b1;
    wait_ts(40);
    check("drain_count", got.size(), 9);
    check("drain_level", fifoLevel, 0);
    for (int i = 0; i < 9; i++) check_got(i, exp_row[i], exp_rise[i], exp_time[i]);

    // Asynchronous reset discards queued events
    eventReady = 1'b0;
    base = got.size();
    set_rows(5'b11111);
    repeat (8) @(negedge clock);
    check("q3_level", fifoLevel, 3);
    check("q3_valid", eventValid, 1);
    #2 resetN = 1'b0;
    #1;
    check("async_valid", eventValid, 0);
    check("async_level", fifoLevel, 0);
    check("async_drop", dropCount, 0);
    set_rows('0);
    eventReady = 1'b1;
    @(negedge clock);
    resetN = 1'b1;
    repeat (10) @(negedge clock);
    check("async_none_emitted", got.size(), base);
    check("async_after_valid", eventValid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
